// File: rtl/fmps_readout_arbiter.sv
// fmps_readout_arbiter
//
// Shares the single read port of the FMPS readout RAM between two requesters:
//   requester 0 - readout stream engine
//   requester 1 - host/CSR debug reader
// One read is issued per cycle. Arbitration is round-robin, with a burst lock
// that lets the last winner keep the port, and an anti-starvation timeout that
// overrides the lock. Every read carries a tag through a pipeline matched to
// the RAM latency, so each response is routed back to the requester that
// issued it, READ_LATENCY+1 clocks after the accept.
//
// Handshake: reqXReady is combinational from the valid/lock inputs and the
// arbiter state. It is never high unless reqXValid is high, and at most one
// ready is high per cycle. A read is accepted at a rising edge where
// reqXValid && reqXReady. Responses have no backpressure: rspXValid is a
// one-cycle pulse that the requester must take.
//
// Ports
//   sysClk, sysReset          clock, asynchronous active-high reset
//   req0Valid/Addr/Lock       stream engine request, address, burst lock
//   req0Ready                 stream engine request accepted this cycle
//   rsp0Valid/Data            stream engine response pulse and data
//   req1* / rsp1*             same for the host reader
//   ramAddress                registered RAM read address
//   ramData                   RAM read data, READ_LATENCY clocks after address
//   dbgLastGrant              requester that won the most recent accept
//   dbgStallCount             current stall counter value

module fmps_readout_arbiter #(
  parameter int INDEX_WIDTH  = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                   sysClk,
  input  logic                   sysReset,
  input  logic                   req0Valid,
  input  logic [INDEX_WIDTH-1:0] req0Addr,
  input  logic                   req0Lock,
  output logic                   req0Ready,
  output logic                   rsp0Valid,
  output logic [DATA_WIDTH-1:0]  rsp0Data,
  input  logic                   req1Valid,
  input  logic [INDEX_WIDTH-1:0] req1Addr,
  input  logic                   req1Lock,
  output logic                   req1Ready,
  output logic                   rsp1Valid,
  output logic [DATA_WIDTH-1:0]  rsp1Data,
  output logic [INDEX_WIDTH-1:0] ramAddress,
  input  logic [DATA_WIDTH-1:0]  ramData,
  output logic                   dbgLastGrant,
  output logic [7:0]             dbgStallCount
);

  localparam logic [7:0] STALL_MAX = 8'(LOCK_TIMEOUT - 1);

  // Arbiter state
  logic       last_grant;    // owner of the port for lock purposes
  logic [7:0] stall_count;   // consecutive cycles someone lost arbitration
  logic       stall_active;  // a requester lost arbitration last cycle
  logic       stall_id;      // which requester lost last cycle

  // Tag pipeline: stage k holds the tag of the read accepted k edges ago
  logic [READ_LATENCY:0] tag_valid;
  logic [READ_LATENCY:0] tag_id;

  logic                   both_valid;
  logic                   owner_lock;
  logic                   accept;
  logic                   grant_id;
  logic [INDEX_WIDTH-1:0] grant_addr;

  always_comb begin
    both_valid = req0Valid & req1Valid;
    owner_lock = last_grant ? req1Lock : req0Lock;
    // Ready is granted whenever anyone asks, so any valid means an accept.
    accept     = req0Valid | req1Valid;
    grant_id   = req1Valid;
    if (both_valid) begin
      // The owner keeps a locked grant until the loser has waited long
      // enough; otherwise the port alternates.
      if (owner_lock && (stall_count != STALL_MAX)) grant_id = last_grant;
      else                                          grant_id = ~last_grant;
    end
    grant_addr = grant_id ? req1Addr : req0Addr;
  end

  assign req0Ready     = accept & ~grant_id;
  assign req1Ready     = accept &  grant_id;
  assign dbgLastGrant  = last_grant;
  assign dbgStallCount = stall_count;

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      last_grant   <= 1'b1;
      stall_count  <= '0;
      stall_active <= 1'b0;
      stall_id     <= 1'b0;
      ramAddress   <= '0;
      tag_valid    <= '0;
      tag_id       <= '0;
      rsp0Valid    <= 1'b0;
      rsp1Valid    <= 1'b0;
      rsp0Data     <= '0;
      rsp1Data     <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant_id;
        ramAddress <= grant_addr;
      end

      // Only a two-way contention can stall anyone. The count restarts when
      // the requester that lost last cycle finally wins.
      if (both_valid) begin
        if (stall_active && (grant_id == stall_id)) stall_count <= '0;
        else if (stall_count != STALL_MAX)          stall_count <= stall_count + 8'd1;
        stall_active <= 1'b1;
        stall_id     <= ~grant_id;
      end else begin
        stall_count  <= '0;
        stall_active <= 1'b0;
      end

      if (READ_LATENCY == 0) begin
        tag_valid <= accept;
        tag_id    <= grant_id;
      end else begin
        tag_valid <= {tag_valid[READ_LATENCY-1:0], accept};
        tag_id    <= {tag_id[READ_LATENCY-1:0], grant_id};
      end

      // The last stage lines up with ramData for the read that owns it.
      rsp0Valid <= tag_valid[READ_LATENCY] & ~tag_id[READ_LATENCY];
      rsp1Valid <= tag_valid[READ_LATENCY] &  tag_id[READ_LATENCY];
      if (tag_valid[READ_LATENCY] && !tag_id[READ_LATENCY]) rsp0Data <= ramData;
      if (tag_valid[READ_LATENCY] &&  tag_id[READ_LATENCY]) rsp1Data <= ramData;
    end
  end

endmodule

// File: tb/tb_fmps_readout_arbiter.sv
// Testbench for fmps_readout_arbiter (READ_LATENCY=3, LOCK_TIMEOUT=8).
// The driver predicts grants and responses from the arbitration rules and
// pushes expected responses into per-requester queues; an independent monitor
// pops and compares whenever the DUT pulses a response.

module tb_fmps_readout_arbiter;

  localparam int IW = 5;
  localparam int DW = 32;
  localparam int RL = 3;
  localparam int LT = 8;

  // ---------------- clock / reset ----------------
  logic sysClk = 1'b0;
  logic sysReset = 1'b1;
  always #5 sysClk = ~sysClk;

  int cyc = 0;
  always @(posedge sysClk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          req0Valid = 1'b0, req0Lock = 1'b0, req0Ready;
  logic [IW-1:0] req0Addr = '0;
  logic          req1Valid = 1'b0, req1Lock = 1'b0, req1Ready;
  logic [IW-1:0] req1Addr = '0;
  logic          rsp0Valid, rsp1Valid;
  logic [DW-1:0] rsp0Data, rsp1Data;
  logic [IW-1:0] ramAddress;
  logic [DW-1:0] ramData;
  logic          dbgLastGrant;
  logic [7:0]    dbgStallCount;

  fmps_readout_arbiter #(
    .INDEX_WIDTH(IW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .LOCK_TIMEOUT(LT)
  ) dut (
    .sysClk(sysClk), .sysReset(sysReset),
    .req0Valid(req0Valid), .req0Addr(req0Addr), .req0Lock(req0Lock), .req0Ready(req0Ready),
    .rsp0Valid(rsp0Valid), .rsp0Data(rsp0Data),
    .req1Valid(req1Valid), .req1Addr(req1Addr), .req1Lock(req1Lock), .req1Ready(req1Ready),
    .rsp1Valid(rsp1Valid), .rsp1Data(rsp1Data),
    .ramAddress(ramAddress), .ramData(ramData),
    .dbgLastGrant(dbgLastGrant), .dbgStallCount(dbgStallCount)
  );

  // ---------------- RAM model: data valid RL clocks after address ----------------
  logic [DW-1:0] mem [32];
  logic [DW-1:0] ram_pipe [RL];
  initial for (int i = 0; i < 32; i++) mem[i] = 32'(i * 3);
  always @(posedge sysClk) begin
    ram_pipe[0] <= mem[ramAddress];
    for (int i = 1; i < RL; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ramData = ram_pipe[RL-1];

  // ---------------- scoreboard ----------------
  // Entry = {due_cycle[15:0], data[31:0]}
  logic [47:0] exp0_q[$];
  logic [47:0] exp1_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_last;      // last granted requester
  int          m_stall;     // stall counter
  bit          m_lost;      // someone lost arbitration last cycle
  int          m_loser;     // who lost
  logic [IW-1:0] m_addr;    // address currently on the RAM port
  logic        s_ready0, s_ready1;

  function automatic void model_reset();
    m_last = 1; m_stall = 0; m_lost = 0; m_loser = 0; m_addr = '0;
  endfunction

  function automatic int model_grant(input logic v0, input logic v1, input logic l0, input logic l1);
    bit owner_locked;
    if (!v0 && !v1) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    owner_locked = (m_last == 1) ? l1 : l0;
    if (owner_locked && m_stall != LT - 1) return m_last;
    return 1 - m_last;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic v0, input logic [IW-1:0] a0, input logic l0,
                             input logic v1, input logic [IW-1:0] a1, input logic l1);
    int g;
    logic [IW-1:0] ga;
    logic [47:0] e;
    req0Valid = v0; req0Addr = a0; req0Lock = l0;
    req1Valid = v1; req1Addr = a1; req1Lock = l1;
    @(negedge sysClk);
    g = model_grant(v0, v1, l0, l1);
    s_ready0 = req0Ready;
    s_ready1 = req1Ready;
    check("ready0", 64'(req0Ready), 64'(g == 0));
    check("ready1", 64'(req1Ready), 64'(g == 1));
    check("ram_address", 64'(ramAddress), 64'(m_addr));
    check("stall_count", 64'(dbgStallCount), 64'(m_stall));
    check("last_grant", 64'(dbgLastGrant), 64'(m_last));
    @(posedge sysClk);
    #1;
    if (g >= 0) begin
      ga = (g == 0) ? a0 : a1;
      e = {16'(cyc + RL + 1), mem[ga]};
      if (g == 0) exp0_q.push_back(e); else exp1_q.push_back(e);
      m_last = g;
      m_addr = ga;
    end
    if (v0 && v1) begin
      if (m_lost && g == m_loser) m_stall = 0;
      else if (m_stall < LT - 1) m_stall++;
      m_lost = 1;
      m_loser = 1 - g;
    end else begin
      m_stall = 0;
      m_lost = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, '0, 0, 0, '0, 0);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && t < 20) begin
      drive_cycle(0, '0, 0, 0, '0, 0);
      t++;
    end
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending0=%0d pending1=%0d required=0", exp0_q.size(), exp1_q.size());
      exp0_q.delete();
      exp1_q.delete();
    end
  endtask

  // ---------------- monitor ----------------
  task automatic pop_check(input int id, input logic [DW-1:0] data);
    logic [47:0] e;
    if (id == 0 && exp0_q.size() == 0 || id == 1 && exp1_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_rsp%0d data=%0h required=no response (cycle %0d)", id, data, cyc);
      return;
    end
    e = (id == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
    check(id == 0 ? "rsp0_data" : "rsp1_data", 64'(data), 64'(e[31:0]));
    check(id == 0 ? "rsp0_cycle" : "rsp1_cycle", 64'(cyc[15:0]), 64'(e[47:32]));
  endtask

  always @(negedge sysClk) begin
    if (sysReset) begin
      check("reset_outputs",
            {31'd0, ramAddress, rsp0Valid, rsp1Valid, dbgLastGrant, dbgStallCount, 16'd0},
            {31'd0, 5'd0, 1'b0, 1'b0, 1'b1, 8'd0, 16'd0});
      check("reset_rsp_data", {rsp0Data, rsp1Data}, 64'd0);
    end else begin
      if (rsp0Valid && rsp1Valid) check("rsp_overlap", 64'd1, 64'd0);
      if (rsp0Valid) pop_check(0, rsp0Data);
      if (rsp1Valid) pop_check(1, rsp1Data);
      if (exp0_q.size() != 0 && exp0_q[0][47:32] < cyc[15:0]) begin
        check("rsp0_missing", 64'(rsp0Valid), 64'd1);
        void'(exp0_q.pop_front());
      end
      if (exp1_q.size() != 0 && exp1_q[0][47:32] < cyc[15:0]) begin
        check("rsp1_missing", 64'(rsp1Valid), 64'd1);
        void'(exp1_q.pop_front());
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int first_r1;
    int r1_count;
    model_reset();
    repeat (3) @(posedge sysClk);
    #1 sysReset = 1'b0;

    // 1: stream engine alone, addresses 0..31 back-to-back
    for (int i = 0; i < 32; i++) drive_cycle(1, 5'(i), 0, 0, '0, 0);
    drain();

    // 2: both requesters, no locks -> alternating grants
    for (int i = 0; i < 8; i++) drive_cycle(1, 5'd5, 0, 1, 5'd9, 0);
    drain();

    // 3: stream engine locked, host starved until the timeout
    first_r1 = -1;
    r1_count = 0;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1, 5'(i + 10), 1, 1, 5'd9, 0);
      if (s_ready1) begin
        r1_count++;
        if (first_r1 < 0) first_r1 = i;
      end
    end
    check("timeout_first_ready1", 64'(first_r1), 64'(LT - 1));
    check("timeout_r1_accepts", 64'(r1_count), 64'd1);
    drain();

    // 4: reset one clock after an accept drops the in-flight read
    drive_cycle(1, 5'd17, 0, 0, '0, 0);
    drive_cycle(0, '0, 0, 0, '0, 0);
    sysReset = 1'b1;
    exp0_q.delete();
    exp1_q.delete();
    model_reset();
    repeat (3) @(posedge sysClk);
    #1 sysReset = 1'b0;
    idle(8);

    // 5: random interleaved traffic with random locks
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    drain();

    // 6: long idle holds the address, no pulses, stall counter at zero
    idle(10);
    @(negedge sysClk);
    check("idle_stall_count", 64'(dbgStallCount), 64'd0);
    check("idle_ram_address", 64'(ramAddress), 64'(m_addr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
